cache_fill_ctrl: RTL
====================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-002 SHALL have parameter BLOCK_WORDS, default 8, words per cache block; power of two, 2..32.
REQ-003 SHALL have parameter WORD_BYTES, default 2, bytes per word; power of two.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum issued-but-unreturned reads; range 1..BLOCK_WORDS.
REQ-005 SHALL have one clock and an asynchronous active-high reset, ports named as follows: clk  in  1  clock, rising edge; rst_n  in  1  asynchronous reset, active-high despite the name.
REQ-006 SHALL have port miss_detected  in  1  tag-match miss, sampled only in IDLE.
REQ-007 SHALL have port miss_address  in  ADDR_W  address that missed.
REQ-008 SHALL have port fsm_busy  out  1  high in FILL and DONE; pipeline stall.
REQ-009 SHALL have port mem_req  out  1  read request valid.
REQ-010 SHALL have port mem_ready  in  1  memory accepts the request this cycle.
REQ-011 SHALL have port memory_address  out  ADDR_W  request address; 0 when mem_req is low.
REQ-012 SHALL have port memory_data_valid  in  1  one returned word, in request order.
REQ-013 SHALL have port memory_data  in  8*WORD_BYTES  returned word.
REQ-014 SHALL have port cache_wen  out  1  write the returned word into the data array.
REQ-015 SHALL have port cache_word  out  log2(BLOCK_WORDS)  word offset of cache_wdata.
REQ-016 SHALL have port cache_wdata  out  8*WORD_BYTES  combinational copy of memory_data.
REQ-017 SHALL have port fill_done  out  1  one-cycle pulse; block complete.

Function
REQ-018 SHALL implement states IDLE, FILL and DONE.
REQ-019 SHALL transition IDLE->FILL on miss_detected and latch the block base (miss_address with offset bits cleared) and the miss word offset.
REQ-020 SHALL transition FILL->DONE on the cycle the BLOCK_WORDS-th word returns, and DONE->IDLE unconditionally after one cycle.
REQ-021 SHALL assert mem_req in FILL while issued < BLOCK_WORDS and outstanding < MAX_OUTSTANDING.
REQ-022 SHALL count a request as issued only when mem_req and mem_ready are both high; the address then advances by WORD_BYTES.
REQ-023 SHALL update outstanding in a single cycle when an issue and a return coincide, leaving it unchanged.
REQ-024 SHALL raise cache_wen combinationally with memory_data_valid in FILL, with cache_word equal to the offset of the oldest unreturned request.
REQ-025 SHALL raise fill_done in DONE only.
REQ-026 SHALL ignore memory_data_valid in IDLE and DONE, and when outstanding equals 0; no write and no counter change.
REQ-027 SHALL ignore miss_detected in FILL and DONE; a new miss is accepted no earlier than the first IDLE cycle.
REQ-028 SHALL wrap word offsets modulo BLOCK_WORDS; memory_address never leaves the block.
REQ-029 SHALL give MAX_OUTSTANDING=1 fully serialised behaviour: one request, wait for data, next request.

Reset
REQ-030 SHALL, on rst_n high at any time including mid-fill, force IDLE and zero all counters, with all outputs 0.
REQ-031 SHALL drop any data returned after reset for an aborted fill, per REQ-026.

Configuration
REQ-032 SHALL, with CACHE_FILL_CWF_EN defined, issue first the missing word offset and then ascending offsets with wrap.
REQ-033 SHALL, with CACHE_FILL_CWF_EN defined, add output crit_valid (1 bit), a one-cycle pulse on the first returned word, allowing early pipeline restart.
REQ-034 SHALL, without CACHE_FILL_CWF_EN, issue offsets 0..BLOCK_WORDS-1 in order and omit crit_valid.

Structure
REQ-035 SHALL place the state enum (IDLE/FILL/DONE) and the default parameter constants in package cache_fill_pkg.
REQ-036 SHALL implement the issue/return offset tracking as sub-module fill_offset_ctr: a modulo counter with load and increment, instantiated twice.

Verification
REQ-037 SHALL cover: defaults, miss at 0x1234, mem_ready=1, valid 4 cycles after each request -> addresses 0x1230, 0x1232 .. 0x123E, 8 writes with offsets 0..7, fill_done one cycle later.
REQ-038 SHALL cover: CACHE_FILL_CWF_EN, miss at 0x00A6 -> addresses 0x00A6, 0x00A8 .. 0x00AE, 0x00A0 .. 0x00A4; crit_valid with offset 3.
REQ-039 SHALL cover: MAX_OUTSTANDING=4, data withheld -> exactly 4 requests, then mem_req low until a word returns.
REQ-040 SHALL cover: mem_ready low for 3 cycles -> memory_address held stable, no issue counted.
REQ-041 SHALL cover: rst_n high after 3 words returned -> IDLE next edge, outputs 0, stray memory_data_valid produces no cache_wen.
REQ-042 SHALL cover: miss_detected held high through DONE -> second fill starts only from IDLE, with no overlap.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// Shared types and default constants for the cache block fill controller.
// Optional critical-word-first ordering is enabled by defining CACHE_FILL_CWF_EN.
package cache_fill_pkg;

  // Fill controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Default parameter values for cache_fill_ctrl
  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_BLOCK_WORDS     = 8;
  localparam int DEF_WORD_BYTES      = 2;
  localparam int DEF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/fill_offset_ctr.sv
// Word-offset counter inside a cache block. Wraps naturally modulo 2**W,
// which equals the block size because the block size is a power of two.
module fill_offset_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Load has priority over increment so a new fill always starts clean
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache block fill controller: on a miss, issues BLOCK_WORDS word reads
// (at most MAX_OUTSTANDING in flight) and writes the returned words into the
// data array in request order. Define CACHE_FILL_CWF_EN to fetch the missing
// word first and expose the crit_valid early-restart pulse.
// Note: rst_n is an asynchronous reset that is active HIGH.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int BLOCK_WORDS     = DEF_BLOCK_WORDS,
  parameter int WORD_BYTES      = DEF_WORD_BYTES,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          miss_detected,
  input  logic [ADDR_W-1:0]             miss_address,
  output logic                          fsm_busy,
  output logic                          mem_req,
  input  logic                          mem_ready,
  output logic [ADDR_W-1:0]             memory_address,
  input  logic                          memory_data_valid,
  input  logic [8*WORD_BYTES-1:0]       memory_data,
  output logic                          cache_wen,
  output logic [$clog2(BLOCK_WORDS)-1:0] cache_word,
  output logic [8*WORD_BYTES-1:0]       cache_wdata,
  output logic                          fill_done
`ifdef CACHE_FILL_CWF_EN
  ,
  output logic                          crit_valid
`endif
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int BYTE_W = $clog2(WORD_BYTES);
  localparam int CNT_W  = OFF_W + 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  BLOCK_CNT = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [OUT_W-1:0]  MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BLOCK_WORDS * WORD_BYTES - 1);

  fill_state_t       r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_returned;
  logic [OUT_W-1:0]  r_outstanding;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_issue;
  logic              w_ret;
  logic [OFF_W-1:0]  w_start_off;
  logic [OFF_W-1:0]  w_issue_off;
  logic [OFF_W-1:0]  w_ret_off;

  assign w_accept = (r_state == IDLE) && miss_detected;

`ifdef CACHE_FILL_CWF_EN
  // The block is fetched starting at the word that actually missed
  assign w_start_off = OFF_W'(miss_address >> BYTE_W);
`else
  assign w_start_off = '0;
`endif

  // Request while words remain to issue and there is room in flight
  assign mem_req = (r_state == FILL) && (r_issued < BLOCK_CNT) && (r_outstanding < MAX_OUT);
  assign w_issue = mem_req && mem_ready;

  // Returns with nothing in flight are stale (e.g. from an aborted fill)
  assign w_ret = (r_state == FILL) && memory_data_valid && (r_outstanding != '0);

  assign memory_address = mem_req ? (r_base | (ADDR_W'(w_issue_off) << BYTE_W)) : '0;
  assign cache_wen      = w_ret;
  assign cache_word     = w_ret ? w_ret_off : '0;
  assign cache_wdata    = memory_data;
  assign fsm_busy       = r_busy;
  assign fill_done      = r_done;

`ifdef CACHE_FILL_CWF_EN
  assign crit_valid = w_ret && (r_returned == '0);
`endif

  fill_offset_ctr #(.W(OFF_W)) u_issue_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (w_start_off),
    .i_inc      (w_issue),
    .o_count    (w_issue_off)
  );

  // Returns arrive in request order, so this tracks the oldest unreturned word
  fill_offset_ctr #(.W(OFF_W)) u_ret_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (w_start_off),
    .i_inc      (w_ret),
    .o_count    (w_ret_off)
  );

  // FSM with issue/return bookkeeping and registered busy/done outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state       <= IDLE;
      r_base        <= '0;
      r_issued      <= '0;
      r_returned    <= '0;
      r_outstanding <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state       <= FILL;
            r_base        <= miss_address & ~OFF_MASK;
            r_issued      <= '0;
            r_returned    <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b1;
          end
        end
        FILL: begin
          if (w_issue) begin
            r_issued <= r_issued + CNT_W'(1);
          end
          if (w_ret) begin
            r_returned <= r_returned + CNT_W'(1);
          end
          // Simultaneous issue and return leave the in-flight count unchanged
          if (w_issue && !w_ret) begin
            r_outstanding <= r_outstanding + OUT_W'(1);
          end else if (!w_issue && w_ret) begin
            r_outstanding <= r_outstanding - OUT_W'(1);
          end
          if (w_ret && (r_returned == LAST_CNT)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
